hazard_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage MIPS core. Each cycle it decides whether the D stage must stall and whether the ID/EX register must load a bubble through its `clear` input. It also generates forwarding selects for the D and E stages. A busy timer for the multiply/divide unit blocks later HI/LO instructions until the current operation completes.

---
 rtl/hazard_pkg.sv | 33 +++
 rtl/md_busy_timer.sv | 30 +++
 rtl/hazard_ctrl.sv | 92 +++++++++
 tb/tb_hazard_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the MIPS hazard controller: tuse/tnew width,
// forward select codes, mul/div op encoding and a destination-match helper.
package hazard_pkg;

  localparam int TW       = 2;
  localparam int RA_W     = 5;
  localparam int MD_CNT_W = 4;

  localparam logic [TW-1:0] TUSE_NONE = 2'd3;

  typedef enum logic [1:0] {
    FWD_RF   = 2'd0,
    FWD_NEAR = 2'd1,
    FWD_FAR  = 2'd2
  } fwd_sel_e;

  typedef enum logic {
    MD_MULT = 1'b0,
    MD_DIV  = 1'b1
  } md_op_e;

  // Destination of an in-flight instruction.
  typedef struct packed {
    logic [RA_W-1:0] addr;
    logic [TW-1:0]   tnew;
  } dst_t;

  // Register 0 is hardwired zero, so it never matches anything.
  function automatic logic dst_hit(input logic [RA_W-1:0] dst, input logic [RA_W-1:0] r);
    return (r != '0) && (dst == r);
  endfunction

endpackage

// File: rtl/md_busy_timer.sv
// Mul/div busy timer: loads the op latency on a start while idle, then counts
// down to zero; busy while nonzero.
module md_busy_timer
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   start,
  input  md_op_e op,
  output logic   busy
);

  logic [MD_CNT_W-1:0] md_cnt;
  logic [MD_CNT_W-1:0] load_val;

  assign load_val = (op == MD_DIV) ? MD_CNT_W'(DIV_CYCLES) : MD_CNT_W'(MULT_CYCLES);

  // A start while busy is dropped; the D-stage stall keeps it from happening.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    md_cnt <= '0;
    else if (start && md_cnt == '0) md_cnt <= load_val;
    else if (md_cnt != '0)          md_cnt <= md_cnt - 1'b1;
  end

  assign busy = (md_cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage MIPS hazard controller: D-stage stall / ID/EX bubble, D and E
// forward selects, mul/div busy interlock and a saturating stall counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [RA_W-1:0] D_rs,
  input  logic [RA_W-1:0] D_rt,
  input  logic [TW-1:0]   D_rs_tuse,
  input  logic [TW-1:0]   D_rt_tuse,
  input  logic            D_is_md,
  input  logic [RA_W-1:0] E_rs,
  input  logic [RA_W-1:0] E_rt,
  input  logic [RA_W-1:0] E_RegAddr,
  input  logic [TW-1:0]   E_tnew,
  input  logic [RA_W-1:0] M_RegAddr,
  input  logic [TW-1:0]   M_tnew,
  input  logic [RA_W-1:0] W_RegAddr,
  input  logic            E_md_start,
  input  logic            E_md_op,
  output logic            stall,
  output logic            E_clear,
  output logic            md_busy,
  output logic [1:0]      fwd_D_rs,
  output logic [1:0]      fwd_D_rt,
  output logic [1:0]      fwd_E_rs,
  output logic [1:0]      fwd_E_rt,
  output logic [31:0]     stall_count
);

  localparam int NUM_OPS = 2;

  dst_t e_dst, m_dst;
  assign e_dst = '{addr: E_RegAddr, tnew: E_tnew};
  assign m_dst = '{addr: M_RegAddr, tnew: M_tnew};

  logic [NUM_OPS-1:0][RA_W-1:0] d_reg, e_reg;
  logic [NUM_OPS-1:0][TW-1:0]   d_tuse;
  logic [NUM_OPS-1:0]           d_haz;
  logic [NUM_OPS-1:0][1:0]      fwd_d, fwd_e;

  assign d_reg  = {D_rt, D_rs};
  assign d_tuse = {D_rt_tuse, D_rs_tuse};
  assign e_reg  = {E_rt, E_rs};

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
    // Stall only if the producer's result will not be ready by the time we use it.
    assign d_haz[i] = (d_tuse[i] != TUSE_NONE) &&
                      ((dst_hit(e_dst.addr, d_reg[i]) && e_dst.tnew > d_tuse[i]) ||
                       (dst_hit(m_dst.addr, d_reg[i]) && m_dst.tnew > d_tuse[i]));

    assign fwd_d[i] = (dst_hit(e_dst.addr, d_reg[i]) && e_dst.tnew == '0) ? FWD_NEAR :
                      (dst_hit(m_dst.addr, d_reg[i]) && m_dst.tnew == '0) ? FWD_FAR  :
                                                                            FWD_RF;

    assign fwd_e[i] = (dst_hit(m_dst.addr, e_reg[i]) && m_dst.tnew == '0) ? FWD_NEAR :
                      dst_hit(W_RegAddr, e_reg[i])                        ? FWD_FAR  :
                                                                            FWD_RF;
  end

  md_busy_timer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_timer (
    .clk   (clk),
    .reset (reset),
    .start (E_md_start),
    .op    (md_op_e'(E_md_op)),
    .busy  (md_busy)
  );

  // md_busy is still low in the start cycle, so the start itself must interlock.
  logic md_haz;
  assign md_haz = D_is_md && (md_busy || E_md_start);

  assign stall    = |d_haz || md_haz;
  assign E_clear  = stall;
  assign fwd_D_rs = fwd_d[0];
  assign fwd_D_rt = fwd_d[1];
  assign fwd_E_rs = fwd_e[0];
  assign fwd_E_rt = fwd_e[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                              stall_count <= '0;
    else if (stall && stall_count != '1)     stall_count <= stall_count + 32'd1;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus randomized inputs checked
// against a rule-level reference model (edge-numbered busy window).
module tb_hazard_ctrl;

  logic        clk, reset;
  logic [4:0]  D_rs, D_rt, E_rs, E_rt, E_RegAddr, M_RegAddr, W_RegAddr;
  logic [1:0]  D_rs_tuse, D_rt_tuse, E_tnew, M_tnew;
  logic        D_is_md, E_md_start, E_md_op;
  logic        stall, E_clear, md_busy;
  logic [1:0]  fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt;
  logic [31:0] stall_count;

  int checks = 0;
  int fails  = 0;

  // Model state: number of the last clock edge, edge after which busy drops, stall count.
  int          now = 0;
  int          busy_until = 0;
  logic [31:0] m_cnt = 0;

  hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .D_rs(D_rs), .D_rt(D_rt), .D_rs_tuse(D_rs_tuse), .D_rt_tuse(D_rt_tuse),
    .D_is_md(D_is_md), .E_rs(E_rs), .E_rt(E_rt),
    .E_RegAddr(E_RegAddr), .E_tnew(E_tnew), .M_RegAddr(M_RegAddr), .M_tnew(M_tnew),
    .W_RegAddr(W_RegAddr), .E_md_start(E_md_start), .E_md_op(E_md_op),
    .stall(stall), .E_clear(E_clear), .md_busy(md_busy),
    .fwd_D_rs(fwd_D_rs), .fwd_D_rt(fwd_D_rt), .fwd_E_rs(fwd_E_rs), .fwd_E_rt(fwd_E_rt),
    .stall_count(stall_count)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic m_busy();
    return now < busy_until;
  endfunction

  function automatic logic m_haz(input logic [4:0] r, input logic [1:0] tu);
    return r != 0 && tu != 2'd3 &&
           ((E_RegAddr == r && E_tnew > tu) || (M_RegAddr == r && M_tnew > tu));
  endfunction

  function automatic logic m_stall();
    return m_haz(D_rs, D_rs_tuse) || m_haz(D_rt, D_rt_tuse) ||
           (D_is_md && (m_busy() || E_md_start));
  endfunction

  function automatic logic [1:0] m_fwd_d(input logic [4:0] r);
    if (r != 0 && E_RegAddr == r && E_tnew == 0) return 2'd1;
    if (r != 0 && M_RegAddr == r && M_tnew == 0) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [1:0] m_fwd_e(input logic [4:0] r);
    if (r != 0 && M_RegAddr == r && M_tnew == 0) return 2'd1;
    if (r != 0 && W_RegAddr == r) return 2'd2;
    return 2'd0;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".stall"},    32'(stall),       32'(m_stall()));
    chk({tag, ".E_clear"},  32'(E_clear),     32'(m_stall()));
    chk({tag, ".md_busy"},  32'(md_busy),     32'(m_busy()));
    chk({tag, ".fwd_D_rs"}, 32'(fwd_D_rs),    32'(m_fwd_d(D_rs)));
    chk({tag, ".fwd_D_rt"}, 32'(fwd_D_rt),    32'(m_fwd_d(D_rt)));
    chk({tag, ".fwd_E_rs"}, 32'(fwd_E_rs),    32'(m_fwd_e(E_rs)));
    chk({tag, ".fwd_E_rt"}, 32'(fwd_E_rt),    32'(m_fwd_e(E_rt)));
    chk({tag, ".cnt"},      stall_count,      m_cnt);
  endtask

  // Advance one clock edge, updating the model from the inputs held across it.
  task automatic step();
    logic s, st;
    int   n;
    s  = m_stall();
    st = E_md_start && !m_busy();
    n  = E_md_op ? 10 : 5;
    @(posedge clk);
    now++;
    if (st) busy_until = now + n;
    if (s && m_cnt != 32'hFFFF_FFFF) m_cnt++;
  endtask

  task automatic clr_in();
    {D_rs, D_rt, E_rs, E_rt, E_RegAddr, M_RegAddr, W_RegAddr} = '0;
    {D_rs_tuse, D_rt_tuse, E_tnew, M_tnew} = '0;
    {D_is_md, E_md_start, E_md_op} = '0;
  endtask

  initial begin
    reset = 0;
    clr_in();
    #2;
    chk("rst.stall", 32'(stall), 0);
    chk("rst.busy",  32'(md_busy), 0);
    chk("rst.fwd",   32'({fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt}), 0);
    chk("rst.cnt",   stall_count, 0);
    @(negedge clk); reset = 1;
    step();

    // Load-use stall, then producer moves to M and finally completes.
    @(negedge clk); clr_in();
    E_RegAddr = 8; E_tnew = 2; D_rs = 8; D_rs_tuse = 1;
    #1 chk("lu.stall", 32'(stall), 1); chk("lu.clear", 32'(E_clear), 1); check_all("lu0");
    step();
    @(negedge clk); E_RegAddr = 0; E_tnew = 0; M_RegAddr = 8; M_tnew = 1;
    #1 chk("lu.nostall", 32'(stall), 0); check_all("lu1");
    step();
    @(negedge clk); M_tnew = 0;
    #1 chk("lu.fwdM", 32'(fwd_D_rs), 2); check_all("lu2");
    step();

    // Register 0 immunity.
    @(negedge clk); clr_in(); E_RegAddr = 0; E_tnew = 2; D_rs = 0; D_rs_tuse = 0;
    #1 chk("r0.stall", 32'(stall), 0); chk("r0.fwd", 32'(fwd_D_rs), 0); check_all("r0");
    step();

    // E-stage forwarding priority M over W.
    @(negedge clk); clr_in(); E_rt = 5; M_RegAddr = 5; W_RegAddr = 5; M_tnew = 0;
    #1 chk("fp.M", 32'(fwd_E_rt), 1); check_all("fp0");
    step();
    @(negedge clk); M_RegAddr = 6;
    #1 chk("fp.W", 32'(fwd_E_rt), 2); check_all("fp1");
    step();

    // Divide busy window with a held mul/div instruction in D.
    @(negedge clk); clr_in(); D_is_md = 1; E_md_start = 1; E_md_op = 1;
    #1 chk("div.busy0", 32'(md_busy), 0); chk("div.stall0", 32'(stall), 1); check_all("div0");
    step();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); E_md_start = 0;
      #1 chk($sformatf("div.busy%0d", i + 1), 32'(md_busy), 1);
      chk($sformatf("div.stall%0d", i + 1), 32'(stall), 1);
      check_all("divw");
      step();
    end
    @(negedge clk);
    #1 chk("div.end", 32'(md_busy), 0); chk("div.endstall", 32'(stall), 0); check_all("dive");
    step();

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk); clr_in(); E_md_start = 1;
    #1 check_all("mr0");
    step();
    @(negedge clk); E_md_start = 0;
    step();
    @(negedge clk); #1 check_all("mr1");
    reset = 0; busy_until = now; m_cnt = 0;
    #1 chk("mr.busy", 32'(md_busy), 0); chk("mr.cnt", stall_count, 0); check_all("mr2");
    #2 reset = 1;
    step();

    // Saturating stall counter.
    @(negedge clk); clr_in();
    force dut.stall_count = 32'hFFFF_FFFE;
    #1 release dut.stall_count;
    m_cnt = 32'hFFFF_FFFE;
    E_RegAddr = 8; E_tnew = 2; D_rs = 8; D_rs_tuse = 0;
    #1 check_all("sat0");
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      #1 chk($sformatf("sat.cnt%0d", i), stall_count, 32'hFFFF_FFFF);
    end
    step();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      D_rs = 5'($urandom_range(0, 3));      D_rt = 5'($urandom_range(0, 3));
      E_rs = 5'($urandom_range(0, 3));      E_rt = 5'($urandom_range(0, 3));
      E_RegAddr = 5'($urandom_range(0, 3)); M_RegAddr = 5'($urandom_range(0, 3));
      W_RegAddr = 5'($urandom_range(0, 3));
      D_rs_tuse = 2'($urandom_range(0, 3)); D_rt_tuse = 2'($urandom_range(0, 3));
      E_tnew = 2'($urandom_range(0, 2));    M_tnew = 2'($urandom_range(0, 1));
      D_is_md = 1'($urandom_range(0, 3) == 0);
      E_md_start = 1'($urandom_range(0, 7) == 0);
      E_md_op = 1'($urandom_range(0, 1));
      #1 check_all("rnd");
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
